// File: rtl/mvu_test_sequencer_pkg.sv
// Shared types and defaults for the MVU test-phase sequencer.
// Phase encoding is visible on the phase output.
package mvu_test_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_RUN,
    PH_TIMEOUT,
    PH_REPORT,
    PH_DONE
  } phase_e;

  localparam int unsigned NCHAN_DEF = 4;
  localparam int unsigned TO_W_DEF  = 24;
  localparam int unsigned CYC_W_DEF = 32;

endpackage

// File: rtl/mvu_test_sequencer_chan.sv
// Per-channel idle watchdog with a sticky done latch.
// Counter is held at zero while clr is high.
module mvu_chan_watchdog
  import mvu_test_sequencer_pkg::*;
#(
  parameter int unsigned TO_W = TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            kick,
  input  logic            done,
  input  logic [TO_W-1:0] limit,
  output logic            expired,
  output logic            done_q
);

  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            done_d, live;

  assign cnt_inc = cnt_q + TO_W'(1);
  assign live    = en & ~done_q & ~done;

  // A done in the expiry cycle wins over the timeout.
  assign expired = live & ~kick
                 & (limit != '0)
                 & (cnt_inc == limit);

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en) begin
      if (done) done_d = 1'b1;
      if (kick || done) begin
        cnt_d = '0;
      end else if (!done_q && cnt_q != '1) begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/mvu_test_sequencer.sv
// Setup/run/report sequencer for multi-MVU benches with
// per-channel idle watchdogs and timeout attribution.
module mvu_test_sequencer
  import mvu_test_sequencer_pkg::*;
#(
  parameter int unsigned NCHAN = NCHAN_DEF,
  parameter int unsigned TO_W  = TO_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TO_W-1:0]  timeout_cycles,
  input  logic [NCHAN-1:0] chan_en,
  output logic             setup_req,
  input  logic             setup_done,
  output logic [NCHAN-1:0] run_start,
  input  logic [NCHAN-1:0] heartbeat,
  input  logic [NCHAN-1:0] run_done,
  output logic             report_req,
  input  logic             report_done,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [NCHAN-1:0] timeout_chan,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [NCHAN-1:0] PH_BIT =
    NCHAN'(1) << (NCHAN - 1);

  phase_e           state_q;
  logic [NCHAN-1:0] chan_en_q;
  logic [TO_W-1:0]  limit_q;
  logic [TO_W-1:0]  ph_cnt_q;
  logic [CYC_W-1:0] cyc_q;
  logic             timed_out_q;
  logic [NCHAN-1:0] tchan_q;
  logic [NCHAN-1:0] run_start_q;
  logic             first_q;

  logic             in_run, busy_w, ph_live, ph_exp;
  logic [TO_W-1:0]  ph_inc, ph_next;
  logic [NCHAN-1:0] exp_vec, done_vec, done_now;
  logic             all_done;

  assign in_run = (state_q == PH_RUN);
  assign busy_w = (state_q == PH_SETUP)
               || (state_q == PH_RUN)
               || (state_q == PH_TIMEOUT)
               || (state_q == PH_REPORT);

  assign ph_live = (state_q == PH_SETUP)
                || (state_q == PH_REPORT);
  assign ph_inc  = ph_cnt_q + TO_W'(1);
  assign ph_next = (ph_cnt_q == '1) ? ph_cnt_q : ph_inc;
  assign ph_exp  = ph_live & (limit_q != '0)
                 & (ph_inc == limit_q);

  for (genvar i = 0; i < NCHAN; i++) begin : g_wd
    mvu_chan_watchdog #(
      .TO_W(TO_W)
    ) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (~in_run),
      .en      (in_run & chan_en_q[i]),
      .kick    (heartbeat[i]),
      .done    (run_done[i] & ~first_q),
      .limit   (limit_q),
      .expired (exp_vec[i]),
      .done_q  (done_vec[i])
    );
  end

  // Disabled channels count as done, so an empty mask leaves RUN at once.
  assign done_now = done_vec
                  | (run_done & {NCHAN{~first_q}});
  assign all_done = &(done_now | ~chan_en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PH_IDLE;
      chan_en_q   <= '0;
      limit_q     <= '0;
      ph_cnt_q    <= '0;
      cyc_q       <= '0;
      timed_out_q <= 1'b0;
      tchan_q     <= '0;
      run_start_q <= '0;
      first_q     <= 1'b0;
    end else begin
      run_start_q <= '0;
      first_q     <= 1'b0;
      ph_cnt_q    <= ph_live ? ph_next : '0;
      if (busy_w && cyc_q != '1) begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
      unique case (state_q)
        PH_IDLE, PH_DONE: begin
          if (start) begin
            state_q     <= PH_SETUP;
            chan_en_q   <= chan_en;
            limit_q     <= timeout_cycles;
            timed_out_q <= 1'b0;
            tchan_q     <= '0;
            cyc_q       <= '0;
            ph_cnt_q    <= '0;
          end
        end
        PH_SETUP: begin
          if (setup_done) begin
            state_q     <= PH_RUN;
            run_start_q <= chan_en_q;
            first_q     <= 1'b1;
            ph_cnt_q    <= '0;
          end else if (ph_exp) begin
            state_q     <= PH_TIMEOUT;
            timed_out_q <= 1'b1;
            tchan_q     <= tchan_q | PH_BIT;
            ph_cnt_q    <= '0;
          end
        end
        PH_RUN: begin
          if (all_done) begin
            state_q <= PH_REPORT;
          end else if (|exp_vec) begin
            state_q     <= PH_TIMEOUT;
            timed_out_q <= 1'b1;
            tchan_q     <= tchan_q | exp_vec;
          end
        end
        PH_TIMEOUT: begin
          state_q <= PH_REPORT;
        end
        PH_REPORT: begin
          if (report_done) begin
            state_q  <= PH_DONE;
            ph_cnt_q <= '0;
          end else if (ph_exp) begin
            state_q     <= PH_DONE;
            timed_out_q <= 1'b1;
            tchan_q     <= tchan_q | PH_BIT;
            ph_cnt_q    <= '0;
          end
        end
        default: state_q <= PH_IDLE;
      endcase
    end
  end

  assign phase        = state_q;
  assign setup_req    = (state_q == PH_SETUP);
  assign report_req   = (state_q == PH_REPORT);
  assign busy         = busy_w;
  assign finished     = (state_q == PH_DONE);
  assign run_start    = run_start_q;
  assign timed_out    = timed_out_q;
  assign timeout_chan = tchan_q;
  assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_mvu_test_sequencer.sv
// Bench for mvu_test_sequencer: directed and random sequences
// checked against a phase-timing model.
module tb_mvu_test_sequencer;
  import mvu_test_sequencer_pkg::*;

  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] tcyc = '0;
  logic [3:0]  chan_en = '0;
  logic        setup_req;
  logic        setup_done = 1'b0;
  logic [3:0]  run_start;
  logic [3:0]  heartbeat = '0;
  logic [3:0]  run_done = '0;
  logic        report_req;
  logic        report_done = 1'b0;
  logic [2:0]  phase;
  logic        busy, finished, timed_out;
  logic [3:0]  tchan;
  logic [31:0] cyc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mvu_test_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .timeout_cycles (tcyc),
    .chan_en        (chan_en),
    .setup_req      (setup_req),
    .setup_done     (setup_done),
    .run_start      (run_start),
    .heartbeat      (heartbeat),
    .run_done       (run_done),
    .report_req     (report_req),
    .report_done    (report_done),
    .phase          (phase),
    .busy           (busy),
    .finished       (finished),
    .timed_out      (timed_out),
    .timeout_chan   (tchan),
    .cycle_count    (cyc)
  );

  // d: RUN cycle of run_done (FFFF = never); hp/hs: heartbeat
  // period/stop; p: REPORT entry cycle; t: DONE cycle.
  typedef struct packed {
    logic [3:0]       en;
    int               lim;
    int               s;
    int               rd;
    logic [3:0][15:0] d;
    logic [3:0][15:0] hp;
    logic [3:0][15:0] hs;
    int               p;
    int               t;
    logic [3:0]       tchan;
    logic             to;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, a, e);
    end
  endtask

  function automatic vec_t mk(
    logic [3:0] en, int lim, int s, int rd,
    logic [63:0] d, logic [63:0] hp, logic [63:0] hs,
    int p, int t, logic [3:0] tc, logic to);
    vec_t v;
    v.en = en; v.lim = lim; v.s = s; v.rd = rd;
    v.d = d; v.hp = hp; v.hs = hs;
    v.p = p; v.t = t; v.tchan = tc; v.to = to;
    return v;
  endfunction

  function automatic int next_hb(int a, int hp, int hs);
    int k;
    if (hp == 0) return INF;
    k = (a < 1) ? 1 : a;
    k = ((k + hp - 1) / hp) * hp;
    return (k < hs) ? k : INF;
  endfunction

  // First run of lim silent cycles, starting at RUN entry or just
  // after an activity; INF when done arrives first.
  function automatic int chan_exp(int d, int hp, int hs, int lim);
    int a, j;
    a = 0;
    for (int g = 0; g < 100000; g++) begin
      j = next_hb(a, hp, hs);
      if (d < j) j = d;
      if (j > a + lim - 1) return a + lim - 1;
      if (j == d) return INF;
      a = j + 1;
    end
    return INF;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t o;
    int r, dmax, emin, e, dd, p;
    o = v;
    o.tchan = '0;
    o.to = 1'b0;
    if (v.s >= v.lim) begin
      p = 2 + v.lim;
      o.tchan[3] = 1'b1;
      o.to = 1'b1;
    end else begin
      r = 2 + v.s;
      dmax = 0;
      emin = INF;
      for (int i = 0; i < 4; i++) begin
        if (v.en[i]) begin
          dd = (v.d[i] == 16'hFFFF) ? INF : int'(v.d[i]);
          if (dd > dmax) dmax = dd;
          e = chan_exp(dd, int'(v.hp[i]), int'(v.hs[i]), v.lim);
          if (e < emin) emin = e;
        end
      end
      if (dmax < emin) begin
        p = r + dmax + 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          dd = (v.d[i] == 16'hFFFF) ? INF : int'(v.d[i]);
          if (v.en[i] && chan_exp(dd, int'(v.hp[i]),
              int'(v.hs[i]), v.lim) == emin)
            o.tchan[i] = 1'b1;
        end
        o.to = 1'b1;
        p = r + emin + 2;
      end
    end
    if (v.rd >= v.lim) begin
      o.t = p + v.lim;
      o.tchan[3] = 1'b1;
      o.to = 1'b1;
    end else begin
      o.t = p + v.rd + 1;
    end
    o.p = p;
    return o;
  endfunction

  task automatic clear_inputs();
    start = 1'b0;
    setup_done = 1'b0;
    report_done = 1'b0;
    run_done = '0;
    heartbeat = '0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int r, dd, hp, hs;
    bit rv, seen;
    r = 2 + v.s;
    rv = (v.s < v.lim);
    seen = 1'b0;
    for (int t = 0; t < v.t + 40; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk($sformatf("v%0d setup_entry", id),
            {phase, setup_req, busy}, {PH_SETUP, 2'b11});
        chk($sformatf("v%0d cleared", id),
            {timed_out, tchan, cyc}, '0);
      end
      if (rv && t == r)
        chk($sformatf("v%0d run_start", id), run_start, v.en);
      if (rv && t == r + 1)
        chk($sformatf("v%0d run_start_off", id), run_start, '0);
      if (t == v.p)
        chk($sformatf("v%0d report_entry", id),
            {phase, report_req}, {PH_REPORT, 1'b1});
      if (t > 0 && finished) begin
        seen = 1'b1;
        chk($sformatf("v%0d done_cycle", id), t, v.t);
        chk($sformatf("v%0d timed_out", id), timed_out, v.to);
        chk($sformatf("v%0d timeout_chan", id), tchan, v.tchan);
        chk($sformatf("v%0d cycle_count", id), cyc, v.t - 1);
        clear_inputs();
        break;
      end
      start = (t == 0) || (rv && t == r + 1 && t < v.p);
      chan_en = v.en;
      tcyc = 24'(v.lim);
      setup_done = (t == 1 + v.s);
      report_done = (t == v.p + v.rd);
      for (int i = 0; i < 4; i++) begin
        dd = int'(v.d[i]);
        hp = int'(v.hp[i]);
        hs = int'(v.hs[i]);
        run_done[i] = (t == r + dd);
        heartbeat[i] = (hp != 0) && (t > r)
                    && ((t - r) % hp == 0) && ((t - r) < hs);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL v%0d finish_bound: finished never seen, want cycle %0d",
               id, v.t);
      clear_inputs();
    end
  endtask

  initial begin
    vec_t v;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {phase, setup_req, report_req, busy, finished,
         timed_out, run_start, tchan, cyc}, '0);
    rst_n = 1'b1;

    vt.push_back(mk(4'hF, 100, 4, 3,
      {16'd40, 16'd30, 16'd20, 16'd10}, '0, '0,
      47, 51, 4'b0000, 1'b0));
    vt.push_back(mk(4'hF, 16, 2, 0,
      {16'd7, 16'd205, 16'd5, 16'd3},
      {16'd0, 16'd10, 16'd0, 16'd0},
      {16'd0, 16'd200, 16'd0, 16'd0},
      210, 211, 4'b0000, 1'b0));
    vt.push_back(mk(4'hF, 16, 0, 2,
      {16'd5, 16'd4, 16'hFFFF, 16'd3}, '0, '0,
      19, 22, 4'b0010, 1'b1));
    vt.push_back(mk(4'h1, 16, 1, 1,
      {16'd2, 16'd2, 16'd2, 16'd15}, '0, '0,
      19, 21, 4'b0000, 1'b0));
    vt.push_back(mk(4'h1, 16, 1, 0,
      {16'd2, 16'd2, 16'd2, 16'd16}, '0, '0,
      20, 21, 4'b0001, 1'b1));
    vt.push_back(mk(4'h0, 16, 0, 0,
      {16'd1, 16'd1, 16'd1, 16'd1}, '0, '0,
      3, 4, 4'b0000, 1'b0));
    vt.push_back(mk(4'hF, 8, 20, 0,
      {16'd2, 16'd2, 16'd2, 16'd2}, '0, '0,
      10, 11, 4'b1000, 1'b1));
    vt.push_back(mk(4'hF, 8, 0, 100,
      {16'd2, 16'd2, 16'd2, 16'd2}, '0, '0,
      5, 13, 4'b1000, 1'b1));

    for (int n = 0; n < 30; n++) begin
      v = '0;
      v.en = 4'($urandom);
      v.lim = int'($urandom_range(4, 40));
      v.s = int'($urandom_range(0, v.lim + 2));
      v.rd = int'($urandom_range(0, v.lim + 2));
      for (int i = 0; i < 4; i++) begin
        v.d[i] = ($urandom % 8 == 0) ? 16'hFFFF
               : 16'($urandom_range(1, 60));
        v.hp[i] = ($urandom % 2 == 0) ? 16'd0
                : 16'($urandom_range(2, v.lim + 3));
        v.hs[i] = 16'($urandom_range(0, 80));
      end
      vt.push_back(model(v));
    end

    foreach (vt[k]) run_vec(vt[k], k);

    // Disabled watchdogs: SETUP must hold indefinitely.
    @(negedge clk);
    start = 1'b1;
    tcyc = '0;
    chan_en = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (9999) @(negedge clk);
    chk("wd_off_phase", {phase, setup_req}, {PH_SETUP, 1'b1});
    chk("wd_off_flags", {timed_out, tchan}, '0);
    chk("wd_off_cycles", cyc, 32'd9999);
    setup_done = 1'b1;
    @(negedge clk);
    setup_done = 1'b0;
    chk("wd_off_run", {phase, run_start}, {PH_RUN, 4'hF});
    repeat (3) @(negedge clk);

    // Asynchronous abort mid-RUN.
    #2 rst_n = 1'b0;
    #1 chk("async_reset",
           {phase, setup_req, report_req, busy, finished,
            timed_out, run_start, tchan, cyc}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
